// File: rtl/drive_mode_arbiter.sv
// drive_mode_arbiter: owns power/run/moving registers, grants one requester.
// Optional idle auto power-off is built when AUTO_POWEROFF_EN is defined.
module drive_mode_arbiter #(
  parameter int HOLD_MS     = 1000,
  parameter int DEBOUNCE_MS = 20,
  parameter int IDLE_MS     = 10000
) (
  input  logic        clk_ms,
  input  logic        rst,
  input  logic        power_on_btn,
  input  logic        power_off_btn,
  input  logic [1:0]  mode_sel,
  input  logic [5:0]  req_state,
  input  logic [11:0] req_moving,
  input  logic [2:0]  req_kill,
  output logic        power,
  output logic [1:0]  state,
  output logic [3:0]  moving_state,
  output logic [1:0]  mode,
  output logic [2:0]  grant,
  output logic        mode_pending,
  output logic        fault
);

  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);

  localparam logic [1:0] NSTART = 2'b00;
  localparam logic [1:0] MOVING = 2'b10;

  typedef enum logic [1:0] {
    P_OFF,
    P_ARMING,
    P_ON
  } pwr_t;

  pwr_t          pst;
  logic [HW-1:0] hold_cnt;
  logic          btn_q;
  logic [1:0]    cand;
  logic [DW-1:0] stab_cnt;
  logic          cand_ok;
  logic          switch_req;
  logic          allowed;
  logic          kill_req;
  logic          idle_to;
  logic [1:0]    sel_st;
  logic [3:0]    sel_mv;
  logic          mv_ok;

  // Candidate mode must stay unchanged for DEBOUNCE_MS cycles.
  always_ff @(posedge clk_ms or negedge rst) begin
    if (!rst) begin
      cand     <= 2'b00;
      stab_cnt <= '0;
    end else if (mode_sel != cand) begin
      cand     <= mode_sel;
      stab_cnt <= '0;
    end else if (stab_cnt != DW'(DEBOUNCE_MS)) begin
      stab_cnt <= stab_cnt + DW'(1);
    end
  end

  assign cand_ok = (stab_cnt == DW'(DEBOUNCE_MS))
                && (cand != 2'b11);
  assign switch_req = cand_ok && (cand != mode);
  assign allowed = (state == NSTART)
                && (moving_state == 4'b0000);

  // Grant decode of the accepted mode while powered.
  always_comb begin
    grant  = 3'b000;
    sel_st = 2'b00;
    sel_mv = 4'b0000;
    unique case (mode)
      2'b00: begin
        grant  = {2'b00, power};
        sel_st = req_state[1:0];
        sel_mv = req_moving[3:0];
      end
      2'b01: begin
        grant  = {1'b0, power, 1'b0};
        sel_st = req_state[3:2];
        sel_mv = req_moving[7:4];
      end
      2'b10: begin
        grant  = {power, 2'b00};
        sel_st = req_state[5:4];
        sel_mv = req_moving[11:8];
      end
      default: begin
        grant  = 3'b000;
        sel_st = 2'b00;
        sel_mv = 4'b0000;
      end
    endcase
  end

  assign mv_ok = (sel_mv & (sel_mv - 4'd1)) == 4'd0;
  assign kill_req = power_off_btn
                 || (|(grant & req_kill))
                 || idle_to;

`ifdef AUTO_POWEROFF_EN
  localparam int IW = $clog2(IDLE_MS + 1);
  logic [IW-1:0] idle_cnt;
  logic          idle_inc;

  assign idle_inc = (pst == P_ON)
                 && (state == NSTART)
                 && !power_off_btn
                 && !power_on_btn
                 && (req_kill == 3'b000);
  assign idle_to = (pst == P_ON)
                && (idle_cnt == IW'(IDLE_MS - 1));

  // Idle cycles while stopped and untouched.
  always_ff @(posedge clk_ms or negedge rst) begin
    if (!rst)
      idle_cnt <= '0;
    else if (idle_inc && !idle_to)
      idle_cnt <= idle_cnt + IW'(1);
    else
      idle_cnt <= '0;
  end
`else
  assign idle_to = 1'b0;
`endif

  // Power sequencing, mode handover and state register update.
  always_ff @(posedge clk_ms or negedge rst) begin
    if (!rst) begin
      pst          <= P_OFF;
      hold_cnt     <= '0;
      btn_q        <= 1'b0;
      power        <= 1'b0;
      state        <= NSTART;
      moving_state <= 4'b0000;
      mode         <= 2'b00;
      mode_pending <= 1'b0;
      fault        <= 1'b0;
    end else begin
      btn_q <= power_on_btn;
      unique case (pst)
        P_OFF: begin
          state        <= NSTART;
          moving_state <= 4'b0000;
          mode_pending <= 1'b0;
          hold_cnt     <= '0;
          if (cand_ok) mode <= cand;
          if (power_on_btn && !btn_q) pst <= P_ARMING;
        end
        P_ARMING: begin
          state        <= NSTART;
          moving_state <= 4'b0000;
          mode_pending <= 1'b0;
          if (cand_ok) mode <= cand;
          if (!power_on_btn || power_off_btn) begin
            pst      <= P_OFF;
            hold_cnt <= '0;
          end else if (hold_cnt == HW'(HOLD_MS - 1)) begin
            pst      <= P_ON;
            power    <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        P_ON: begin
          if (kill_req) begin
            pst          <= P_OFF;
            power        <= 1'b0;
            state        <= NSTART;
            moving_state <= 4'b0000;
            mode_pending <= 1'b0;
            fault        <= 1'b0;
          end else if (switch_req && allowed) begin
            mode         <= cand;
            mode_pending <= 1'b0;
            state        <= NSTART;
            moving_state <= 4'b0000;
          end else begin
            if (switch_req) mode_pending <= 1'b1;
            else if (cand_ok) mode_pending <= 1'b0;
            if (sel_st == 2'b11) begin
              fault <= 1'b1;
            end else if (sel_st != MOVING) begin
              state        <= sel_st;
              moving_state <= 4'b0000;
            end else begin
              state <= sel_st;
              if (mv_ok) moving_state <= sel_mv;
              else fault <= 1'b1;
            end
          end
        end
        default: begin
          pst   <= P_OFF;
          power <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// tb_drive_mode_arbiter: directed scenario tasks for drive_mode_arbiter.
// Idle auto power-off is exercised when AUTO_POWEROFF_EN is defined.
module tb_drive_mode_arbiter;

  logic        clk_ms;
  logic        rst;
  logic        power_on_btn;
  logic        power_off_btn;
  logic [1:0]  mode_sel;
  logic [5:0]  req_state;
  logic [11:0] req_moving;
  logic [2:0]  req_kill;
  logic        power;
  logic [1:0]  state;
  logic [3:0]  moving_state;
  logic [1:0]  mode;
  logic [2:0]  grant;
  logic        mode_pending;
  logic        fault;

  int pass_cnt;
  int total_cnt;

  drive_mode_arbiter #(
    .HOLD_MS(1000),
    .DEBOUNCE_MS(20),
    .IDLE_MS(100)
  ) dut (
    .clk_ms(clk_ms),
    .rst(rst),
    .power_on_btn(power_on_btn),
    .power_off_btn(power_off_btn),
    .mode_sel(mode_sel),
    .req_state(req_state),
    .req_moving(req_moving),
    .req_kill(req_kill),
    .power(power),
    .state(state),
    .moving_state(moving_state),
    .mode(mode),
    .grant(grant),
    .mode_pending(mode_pending),
    .fault(fault)
  );

  initial clk_ms = 1'b0;
  always #5 clk_ms = ~clk_ms;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_ms);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    power_on_btn = 1'b0;
    power_off_btn = 1'b0;
    mode_sel = 2'b00;
    req_state = '0;
    req_moving = '0;
    req_kill = '0;
    tick(3);
    total_cnt++;
    if ({power, state, moving_state, mode,
         grant, mode_pending, fault} !== 14'd0)
      $display("FAIL reset outs=%b exp=0",
        {power, state, moving_state, mode,
         grant, mode_pending, fault});
    else pass_cnt++;
    rst = 1'b1;
    tick(2);
    total_cnt++;
    if (power !== 1'b0 || grant !== 3'b000)
      $display("FAIL post_reset power=%b grant=%b exp 0/000",
        power, grant);
    else pass_cnt++;
  endtask

  task automatic test_power_up;
    power_on_btn = 1'b1;
    tick(999);
    power_on_btn = 1'b0;
    tick(2);
    total_cnt++;
    if (power !== 1'b0)
      $display("FAIL early_release power=%b exp=0", power);
    else pass_cnt++;
    power_on_btn = 1'b1;
    tick(1000);
    total_cnt++;
    if (power !== 1'b0)
      $display("FAIL hold_999 power=%b exp=0", power);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (power !== 1'b1 || grant !== 3'b001)
      $display("FAIL hold_1000 power=%b grant=%b exp 1/001",
        power, grant);
    else pass_cnt++;
    power_on_btn = 1'b0;
    tick(1);
  endtask

  task automatic test_manual_drive;
    req_state = 6'b00_00_10;
    req_moving = 12'h001;
    req_kill = 3'b010;
    tick(1);
    total_cnt++;
    if (state !== 2'b10 || moving_state !== 4'b0001)
      $display("FAIL manual_fwd st=%b mv=%b exp 10/0001",
        state, moving_state);
    else pass_cnt++;
    total_cnt++;
    if (power !== 1'b1)
      $display("FAIL semi_kill_ignored power=%b exp=1", power);
    else pass_cnt++;
    req_kill = 3'b000;
    req_moving = 12'h004;
    tick(1);
    total_cnt++;
    if (moving_state !== 4'b0100)
      $display("FAIL manual_left mv=%b exp=0100", moving_state);
    else pass_cnt++;
  endtask

  task automatic test_deferred_switch;
    mode_sel = 2'b10;
    tick(25);
    total_cnt++;
    if (mode_pending !== 1'b1 || mode !== 2'b00
        || grant !== 3'b001)
      $display("FAIL pending pend=%b mode=%b grant=%b exp 1/00/001",
        mode_pending, mode, grant);
    else pass_cnt++;
    req_state = 6'b00_00_00;
    req_moving = 12'h000;
    tick(1);
    total_cnt++;
    if (state !== 2'b00 || mode !== 2'b00)
      $display("FAIL stop st=%b mode=%b exp 00/00", state, mode);
    else pass_cnt++;
    req_state = 6'b10_00_10;
    req_moving = 12'h102;
    tick(1);
    total_cnt++;
    if (mode !== 2'b10 || mode_pending !== 1'b0
        || state !== 2'b00 || moving_state !== 4'b0000)
      $display("FAIL handover mode=%b pend=%b st=%b mv=%b exp 10/0/00/0000",
        mode, mode_pending, state, moving_state);
    else pass_cnt++;
    total_cnt++;
    if (grant !== 3'b100)
      $display("FAIL grant_auto grant=%b exp=100", grant);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (state !== 2'b10 || moving_state !== 4'b0001)
      $display("FAIL auto_drive st=%b mv=%b exp 10/0001",
        state, moving_state);
    else pass_cnt++;
    req_state = 6'b00_00_00;
    req_moving = 12'h000;
    tick(1);
  endtask

  task automatic test_invalid;
    mode_sel = 2'b11;
    tick(50);
    total_cnt++;
    if (mode !== 2'b10 || mode_pending !== 1'b0)
      $display("FAIL mode_11 mode=%b pend=%b exp 10/0",
        mode, mode_pending);
    else pass_cnt++;
    mode_sel = 2'b10;
    req_state = 6'b11_00_00;
    req_moving = 12'h100;
    tick(1);
    total_cnt++;
    if (state !== 2'b00 || moving_state !== 4'b0000
        || fault !== 1'b1)
      $display("FAIL state_11 st=%b mv=%b fault=%b exp 00/0000/1",
        state, moving_state, fault);
    else pass_cnt++;
    req_state = 6'b10_00_00;
    req_moving = 12'h100;
    tick(1);
    req_moving = 12'h300;
    tick(1);
    total_cnt++;
    if (moving_state !== 4'b0001 || fault !== 1'b1)
      $display("FAIL bad_moving mv=%b fault=%b exp 0001/1",
        moving_state, fault);
    else pass_cnt++;
    power_off_btn = 1'b1;
    tick(1);
    power_off_btn = 1'b0;
    total_cnt++;
    if (power !== 1'b0 || fault !== 1'b0 || state !== 2'b00
        || grant !== 3'b000)
      $display("FAIL off_clears pwr=%b fault=%b st=%b grant=%b exp 0/0/00/000",
        power, fault, state, grant);
    else pass_cnt++;
    req_state = '0;
    req_moving = '0;
  endtask

  task automatic test_poweroff_precedence;
    mode_sel = 2'b00;
    power_on_btn = 1'b1;
    tick(1001);
    power_on_btn = 1'b0;
    total_cnt++;
    if (power !== 1'b1 || mode !== 2'b00 || grant !== 3'b001)
      $display("FAIL repower pwr=%b mode=%b grant=%b exp 1/00/001",
        power, mode, grant);
    else pass_cnt++;
    req_state = 6'b00_00_10;
    req_moving = 12'h008;
    tick(1);
    total_cnt++;
    if (state !== 2'b10 || moving_state !== 4'b1000)
      $display("FAIL right st=%b mv=%b exp 10/1000",
        state, moving_state);
    else pass_cnt++;
    power_off_btn = 1'b1;
    req_moving = 12'h004;
    tick(1);
    power_off_btn = 1'b0;
    total_cnt++;
    if (power !== 1'b0 || state !== 2'b00
        || moving_state !== 4'b0000 || grant !== 3'b000)
      $display("FAIL off_wins pwr=%b st=%b mv=%b grant=%b exp 0/00/0000/000",
        power, state, moving_state, grant);
    else pass_cnt++;
    req_state = '0;
    req_moving = '0;
  endtask

  task automatic test_kill_rearm;
    power_on_btn = 1'b1;
    tick(1001);
    req_kill = 3'b010;
    tick(1);
    total_cnt++;
    if (power !== 1'b1)
      $display("FAIL nongrant_kill power=%b exp=1", power);
    else pass_cnt++;
    req_kill = 3'b001;
    tick(1);
    req_kill = 3'b000;
    total_cnt++;
    if (power !== 1'b0)
      $display("FAIL grant_kill power=%b exp=0", power);
    else pass_cnt++;
    tick(1100);
    total_cnt++;
    if (power !== 1'b0)
      $display("FAIL held_no_rearm power=%b exp=0", power);
    else pass_cnt++;
    power_on_btn = 1'b0;
    tick(1);
    power_on_btn = 1'b1;
    tick(1000);
    total_cnt++;
    if (power !== 1'b0)
      $display("FAIL rearm_999 power=%b exp=0", power);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (power !== 1'b1)
      $display("FAIL rearm_1000 power=%b exp=1", power);
    else pass_cnt++;
    power_on_btn = 1'b0;
    tick(1);
  endtask

  task automatic test_idle;
`ifdef AUTO_POWEROFF_EN
    tick(50);
    total_cnt++;
    if (power !== 1'b1)
      $display("FAIL idle_50 power=%b exp=1", power);
    else pass_cnt++;
    tick(60);
    total_cnt++;
    if (power !== 1'b0)
      $display("FAIL idle_off power=%b exp=0", power);
    else pass_cnt++;
    power_on_btn = 1'b1;
    tick(1001);
    power_on_btn = 1'b0;
    tick(50);
    power_off_btn = 1'b1;
    tick(1);
    power_off_btn = 1'b0;
    total_cnt++;
    if (power !== 1'b0)
      $display("FAIL idle_btn_off power=%b exp=0", power);
    else pass_cnt++;
`else
    tick(250);
    total_cnt++;
    if (power !== 1'b1 || grant !== 3'b001)
      $display("FAIL stays_on power=%b grant=%b exp 1/001",
        power, grant);
    else pass_cnt++;
`endif
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_power_up();
    test_manual_drive();
    test_deferred_switch();
    test_invalid();
    test_poweroff_precedence();
    test_kill_rearm();
    test_idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
